// File: rtl/recon4_sched.sv
// recon4_sched -- sequencer for intra-4x4 luma reconstruction of one macroblock.
//
// Walks NUM_BLK 4x4 sub-blocks in raster order, strictly one at a time, because
// each block's intra prediction needs its already-reconstructed neighbours.
// Per block: request the prediction (REQ), kick the reconstruct datapath (KICK),
// wait for its done pulse (WAIT), then write the result back (WB). FIN marks the
// end of the macroblock. A stalled datapath is abandoned after TIMEOUT WAIT
// cycles and reported through the sticky err flag.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   mb_start    : one-cycle request to process a macroblock (IDLE only)
//   abort       : synchronous cancel of the current macroblock
//   pred_req    : prediction request for blk_idx (high throughout REQ)
//   pred_ready  : prediction / source / quant tables for blk_idx are stable
//   rc_start    : one-cycle start pulse to the 4x4 reconstruct datapath
//   rc_done     : datapath done pulse
//   rc_nz       : datapath nonzero flag, valid with rc_done
//   blk_idx     : current sub-block index
//   wr_en       : one-cycle store strobe for Yout/YLevels
//   wr_idx      : store address
//   nz_mask     : per-block nonzero bitmap
//   busy        : high in every state except IDLE
//   mb_done     : one-cycle macroblock completion pulse
//   err         : sticky timeout flag
module recon4_sched #(
  parameter int NUM_BLK = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mb_start,
  input  logic        abort,
  output logic        pred_req,
  input  logic        pred_ready,
  output logic        rc_start,
  input  logic        rc_done,
  input  logic        rc_nz,
  output logic [3:0]  blk_idx,
  output logic        wr_en,
  output logic [3:0]  wr_idx,
  output logic [15:0] nz_mask,
  output logic        busy,
  output logic        mb_done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_KICK = 3'd2,
    S_WAIT = 3'd3,
    S_WB   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam logic [3:0]  LAST_BLK = 4'(NUM_BLK - 1);
  // The counter holds TIMEOUT-1 during the TIMEOUT-th WAIT cycle.
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [15:0] NZ_VALID = 16'((32'd1 << NUM_BLK) - 32'd1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_pred_req, r_rc_start, r_wr_en, r_busy, r_mb_done;
  logic        w_pred_req, w_rc_start, w_wr_en, w_busy, w_mb_done;
  logic [3:0]  r_blk_idx;
  logic [3:0]  r_wr_idx;
  logic [15:0] r_nz_mask;
  logic [15:0] w_nz_set;
  logic        r_err;
  logic [7:0]  r_tmo;

  // State register plus registered copies of the state-decoded outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pred_req <= 1'b0;
      r_rc_start <= 1'b0;
      r_wr_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_mb_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pred_req <= w_pred_req;
      r_rc_start <= w_rc_start;
      r_wr_en    <= w_wr_en;
      r_busy     <= w_busy;
      r_mb_done  <= w_mb_done;
    end
  end

  // Next-state logic; abort outranks rc_done and the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mb_start) w_state_nxt = S_REQ;
        else          w_state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (pred_ready) w_state_nxt = S_KICK;
        else                 w_state_nxt = S_REQ;
      end
      S_KICK: begin
        if (abort) w_state_nxt = S_IDLE;
        else       w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (abort)                  w_state_nxt = S_IDLE;
        else if (rc_done)           w_state_nxt = S_WB;
        else if (r_tmo == TMO_LAST) w_state_nxt = S_IDLE;
        else                        w_state_nxt = S_WAIT;
      end
      S_WB: begin
        if (abort)                       w_state_nxt = S_IDLE;
        else if (r_blk_idx == LAST_BLK)  w_state_nxt = S_FIN;
        else                             w_state_nxt = S_REQ;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with the state.
  always_comb begin
    w_pred_req = (w_state_nxt == S_REQ);
    w_rc_start = (w_state_nxt == S_KICK);
    w_wr_en    = (w_state_nxt == S_WB);
    w_mb_done  = (w_state_nxt == S_FIN);
    w_busy     = (w_state_nxt != S_IDLE);
  end

  // Nonzero bitmap with the current block's flag merged in; bits past NUM_BLK stay clear.
  always_comb begin
    w_nz_set            = r_nz_mask;
    w_nz_set[r_blk_idx] = rc_nz;
    w_nz_set            = w_nz_set & NZ_VALID;
  end

  // Block index, write address, nonzero bitmap, timeout counter and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_idx <= 4'd0;
      r_wr_idx  <= 4'd0;
      r_nz_mask <= 16'h0000;
      r_err     <= 1'b0;
      r_tmo     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mb_start) begin
            r_blk_idx <= 4'd0;
            r_nz_mask <= 16'h0000;
            r_err     <= 1'b0;
            r_tmo     <= 8'd0;
          end
        end
        S_KICK: r_tmo <= 8'd0;
        S_WAIT: begin
          if (!abort) begin
            r_tmo <= r_tmo + 8'd1;
            if (rc_done) begin
              r_nz_mask <= w_nz_set;
              r_wr_idx  <= r_blk_idx;
            end else if (r_tmo == TMO_LAST) begin
              r_err <= 1'b1;
            end
          end
        end
        S_WB: begin
          if (!abort && (r_blk_idx != LAST_BLK)) r_blk_idx <= r_blk_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign pred_req = r_pred_req;
  assign rc_start = r_rc_start;
  assign wr_en    = r_wr_en;
  assign busy     = r_busy;
  assign mb_done  = r_mb_done;
  assign blk_idx  = r_blk_idx;
  assign wr_idx   = r_wr_idx;
  assign nz_mask  = r_nz_mask;
  assign err      = r_err;

endmodule

// File: tb/tb_recon4_sched.sv
// Directed bench for recon4_sched (NUM_BLK=16, TIMEOUT=8).
// The datapath model captures rc_start and answers three cycles later, so
// rc_done is seen in the fourth WAIT cycle: 7 cycles per block, FIN at 16*7+1.
module tb_recon4_sched;

  logic        clk = 1'b0;
  logic        rst, mb_start, abort, pred_ready, rc_done, rc_nz;
  logic        pred_req, rc_start, wr_en, busy, mb_done, err;
  logic [3:0]  blk_idx, wr_idx;
  logic [15:0] nz_mask;

  always #5 clk = ~clk;

  recon4_sched #(.NUM_BLK(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .mb_start(mb_start), .abort(abort),
    .pred_req(pred_req), .pred_ready(pred_ready), .rc_start(rc_start),
    .rc_done(rc_done), .rc_nz(rc_nz), .blk_idx(blk_idx), .wr_en(wr_en),
    .wr_idx(wr_idx), .nz_mask(nz_mask), .busy(busy), .mb_done(mb_done), .err(err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dp_cnt, lo_blk, lo_cnt, wh_blk, ab_blk, sp_blk, sb_blk;
  bit sp_done, sb_done;
  int wr_cnt, rs_cnt, md_cnt, md_cyc, pr_cnt, kick_cyc, start_cyc, end_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pred_req"}, 32'(pred_req), 32'd0);
    chk({tag, "_rc_start"}, 32'(rc_start), 32'd0);
    chk({tag, "_blk_idx"},  32'(blk_idx),  32'd0);
    chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
    chk({tag, "_wr_idx"},   32'(wr_idx),   32'd0);
    chk({tag, "_nz_mask"},  32'(nz_mask),  32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_mb_done"},  32'(mb_done),  32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
  endtask

  task automatic reset_cfg();
    dp_cnt = 0; lo_blk = -1; lo_cnt = 0; wh_blk = -1; ab_blk = -1;
    sp_blk = -1; sb_blk = -1; sp_done = 1'b0; sb_done = 1'b0;
    wr_cnt = 0; rs_cnt = 0; md_cnt = 0; md_cyc = -1; pr_cnt = 0; kick_cyc = -1;
  endtask

  // One clock: observe the cycle's outputs, then drive this cycle's inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rc_start) begin
      rs_cnt++;
      if (int'(blk_idx) == lo_blk) kick_cyc = cyc - start_cyc;
    end
    if (wr_en) begin
      chk("wr_idx_seq", 32'(wr_idx), 32'(wr_cnt));
      wr_cnt++;
    end
    if (mb_done) begin
      md_cnt++;
      md_cyc = cyc - start_cyc;
    end
    if (pred_req) pr_cnt++;
    mb_start = 1'b0; abort = 1'b0; rc_done = 1'b0; rc_nz = 1'b0; pred_ready = 1'b1;
    if (dp_cnt > 0) begin
      dp_cnt--;
      if (dp_cnt == 0 && int'(blk_idx) != wh_blk) begin
        rc_done = 1'b1;
        rc_nz   = blk_idx[0];
        if (int'(blk_idx) == ab_blk) abort = 1'b1;
      end
    end
    if (rc_start) dp_cnt = 4;
    if (pred_req && int'(blk_idx) == lo_blk && lo_cnt < 10) begin
      pred_ready = 1'b0;
      lo_cnt++;
    end
    if (pred_req && int'(blk_idx) == sp_blk && !sp_done) begin
      rc_done = 1'b1; rc_nz = 1'b1; sp_done = 1'b1;
    end
    if (rc_start && int'(blk_idx) == sb_blk && !sb_done) begin
      mb_start = 1'b1; sb_done = 1'b1;
    end
  endtask

  // Start a macroblock and run until the scheduler drops back to IDLE.
  task automatic run_mb(input string tag);
    step();
    mb_start  = 1'b1;
    start_cyc = cyc;
    step();
    chk({tag, "_start_blk"},  32'(blk_idx),  32'd0);
    chk({tag, "_start_nz"},   32'(nz_mask),  32'd0);
    chk({tag, "_start_err"},  32'(err),      32'd0);
    chk({tag, "_start_preq"}, 32'(pred_req), 32'd1);
    for (int i = 0; i < 400 && busy; i++) step();
    end_cyc = cyc - start_cyc;
    chk({tag, "_idle_bound"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_full(input string tag, input int exp_done);
    chk({tag, "_mb_done_cyc"}, 32'(md_cyc),  32'(exp_done));
    chk({tag, "_mb_done_cnt"}, 32'(md_cnt),  32'd1);
    chk({tag, "_rc_start_cnt"},32'(rs_cnt),  32'd16);
    chk({tag, "_wr_en_cnt"},   32'(wr_cnt),  32'd16);
    chk({tag, "_nz_mask"},     32'(nz_mask), 32'h0000AAAA);
    chk({tag, "_err"},         32'(err),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mb_start = 1'b0; abort = 1'b0; pred_ready = 1'b0;
    rc_done = 1'b0; rc_nz = 1'b0;
    reset_cfg();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst_init");
    rst = 1'b0;

    // abort in IDLE has no effect
    step();
    abort = 1'b1;
    step();
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_preq", 32'(pred_req), 32'd0);

    // Nominal macroblock: FIN at cycle 113, odd blocks nonzero
    reset_cfg();
    run_mb("nominal");
    chk_full("nominal", 113);
    chk("nominal_end_cyc", 32'(end_cyc), 32'd114);
    chk("nominal_preq_cnt", 32'(pr_cnt), 32'd16);

    // pred_ready withheld 10 cycles on block 5
    reset_cfg();
    lo_blk = 5;
    run_mb("stall");
    chk_full("stall", 123);
    chk("stall_kick5_cyc", 32'(kick_cyc), 32'd47);
    chk("stall_preq_cnt", 32'(pr_cnt), 32'd26);

    // rc_done withheld on block 3: timeout after 8 WAIT cycles
    reset_cfg();
    wh_blk = 3;
    run_mb("tmo");
    chk("tmo_end_cyc", 32'(end_cyc), 32'd32);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_mb_done_cnt", 32'(md_cnt), 32'd0);
    chk("tmo_wr_en_cnt", 32'(wr_cnt), 32'd3);
    chk("tmo_rc_start_cnt", 32'(rs_cnt), 32'd4);
    chk("tmo_nz_mask", 32'(nz_mask), 32'h00000002);
    step();
    chk("tmo_err_sticky", 32'(err), 32'd1);

    // abort together with rc_done on block 7 (err cleared by the new start)
    reset_cfg();
    ab_blk = 7;
    run_mb("abort");
    chk("abort_end_cyc", 32'(end_cyc), 32'd56);
    chk("abort_wr_en_cnt", 32'(wr_cnt), 32'd7);
    chk("abort_mb_done_cnt", 32'(md_cnt), 32'd0);
    chk("abort_nz_mask", 32'(nz_mask), 32'h0000002A);
    chk("abort_err", 32'(err), 32'd0);

    // Restart after abort, with mb_start while busy and a spurious rc_done in REQ
    reset_cfg();
    sp_blk = 2;
    sb_blk = 4;
    run_mb("spur");
    chk_full("spur", 113);
    chk("spur_end_cyc", 32'(end_cyc), 32'd114);

    // Asynchronous reset in the middle of WAIT on block 9
    reset_cfg();
    step();
    mb_start  = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < 200; i++) begin
      step();
      if (rc_start && blk_idx == 4'd9) break;
    end
    chk("rst9_find_kick", 32'(rc_start), 32'd1);
    step();
    step();
    chk("rst9_pre_blk", 32'(blk_idx), 32'd9);
    chk("rst9_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    dp_cnt = 0;
    step();
    step();
    rst = 1'b0;
    reset_cfg();
    run_mb("post_rst");
    chk_full("post_rst", 113);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
